// File: rtl/axilite_cmd_master.sv
// axilite_cmd_master: single-outstanding AXI4-Lite initiator fed by a valid/ready command port.
// Optional macro AXILITE_CMD_TIMEOUT_EN bounds the B/R wait to TIMEOUT_CYCLES and orphans late beats.
module axilite_cmd_master #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [3:0]    cmd_wstrb,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [1:0]    rsp_resp,
    output logic          rsp_timeout,
    output logic [AW-1:0] awaddr,
    output logic [2:0]    awprot,
    output logic          awvalid,
    input  logic          awready,
    output logic [DW-1:0] wdata,
    output logic [3:0]    wstrb,
    output logic          wvalid,
    input  logic          wready,
    input  logic [1:0]    bresp,
    input  logic          bvalid,
    output logic          bready,
    output logic [AW-1:0] araddr,
    output logic [2:0]    arprot,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0] wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [1:0]    rsp_resp_q, rsp_resp_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic          bready_q, bready_d, rready_q, rready_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic          cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic          orphan, to_hit;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign aw_hs  = awvalid_q && awready;
    assign w_hs   = wvalid_q && wready;
    assign b_hs   = bvalid && bready_q;
    assign ar_hs  = arvalid_q && arready;
    assign r_hs   = rvalid && rready_q;

`ifdef AXILITE_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          orphan_q, orphan_d, rsp_timeout_q, rsp_timeout_d;

    assign orphan = orphan_q;
    assign to_hit = (state_q == WRESP || state_q == RDATA) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign orphan = 1'b0;
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cmd_hs) state_d = cmd_write ? WADDR : RADDR;
            WADDR:   if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
            WRESP:   if (b_hs || to_hit) state_d = RSP;
            RADDR:   if (ar_hs) state_d = RDATA;
            RDATA:   if (r_hs || to_hit) state_d = RSP;
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        araddr_d    = araddr_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXILITE_CMD_TIMEOUT_EN
        cnt_d         = cnt_q;
        orphan_d      = orphan_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_hs && cmd_write) begin
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (cmd_hs) begin
                    araddr_d  = cmd_addr;
                    arvalid_d = 1'b1;
                end
            end
            WADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (state_d == WRESP) bready_d = 1'b1;
            end
            WRESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = bresp;
                    rsp_rdata_d = '0;
                end
            end
            RADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RDATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                end
            end
            default: ;
        endcase
`ifdef AXILITE_CMD_TIMEOUT_EN
        if (state_q == WRESP || state_q == RDATA) begin
            cnt_d = cnt_q + 1'b1;
            if (state_d == RSP) rsp_timeout_d = 1'b0;
            // Timed out: answer with SLVERR but keep bready/rready up to swallow the late beat.
            if (state_d == RSP && !(b_hs || r_hs)) begin
                rsp_resp_d    = 2'b10;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b1;
                orphan_d      = 1'b1;
            end
        end
        if (state_d != state_q && (state_d == WRESP || state_d == RDATA)) cnt_d = '0;
        if (orphan_q && (b_hs || r_hs)) begin
            orphan_d = 1'b0;
            bready_d = 1'b0;
            rready_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            araddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            araddr_q    <= araddr_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

`ifdef AXILITE_CMD_TIMEOUT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q         <= '0;
            orphan_q      <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            orphan_q      <= orphan_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        cmd_ready = (state_q == IDLE) && !orphan;
        rsp_valid = (state_q == RSP);
        rsp_rdata = rsp_rdata_q;
        rsp_resp  = rsp_resp_q;
        awaddr    = awaddr_q;
        awprot    = 3'b000;
        awvalid   = awvalid_q;
        wdata     = wdata_q;
        wstrb     = wstrb_q;
        wvalid    = wvalid_q;
        bready    = bready_q;
        araddr    = araddr_q;
        arprot    = 3'b000;
        arvalid   = arvalid_q;
        rready    = rready_q;
    end

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Self-checking bench for axilite_cmd_master: scripted AXI4-Lite responder plus response scoreboard.
`timescale 1ns/1ps
module tb_axilite_cmd_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axilite_cmd_master #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    int          aw_lat, w_lat, b_wait, r_wait;
    logic [1:0]  cfg_bresp, cfg_rresp;
    logic [31:0] cfg_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Responder: samples handshakes before each edge, updates its outputs 1ns after it.
    bit rs_aw_hs, rs_w_hs, rs_b_hs, rs_ar_hs, rs_r_hs;
    bit rs_aw_seen, rs_w_seen, rs_b_pend, rs_r_pend;
    int rs_aw_cnt, rs_w_cnt, rs_b_cnt, rs_r_cnt;

    initial begin : responder
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        rs_aw_seen = 0; rs_w_seen = 0; rs_b_pend = 0; rs_r_pend = 0;
        rs_aw_cnt = 0; rs_w_cnt = 0; rs_b_cnt = 0; rs_r_cnt = 0;
        forever begin
            @(negedge aclk);
            rs_aw_hs = awvalid && awready;
            rs_w_hs  = wvalid && wready;
            rs_b_hs  = bvalid && bready;
            rs_ar_hs = arvalid && arready;
            rs_r_hs  = rvalid && rready;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                rs_aw_seen = 0; rs_w_seen = 0; rs_b_pend = 0; rs_r_pend = 0;
                rs_aw_cnt = 0; rs_w_cnt = 0;
                continue;
            end
            if (rs_aw_hs) rs_aw_seen = 1;
            if (rs_w_hs)  rs_w_seen = 1;
            if (rs_b_hs)  bvalid = 0;
            if (rs_r_hs)  rvalid = 0;
            if (rs_aw_seen && rs_w_seen) begin
                rs_aw_seen = 0; rs_w_seen = 0; rs_b_pend = 1; rs_b_cnt = 0;
            end
            if (rs_ar_hs) begin
                rs_r_pend = 1; rs_r_cnt = 0;
            end
            if (rs_b_pend) begin
                if (rs_b_cnt >= b_wait) begin
                    bvalid = 1; bresp = cfg_bresp; rs_b_pend = 0;
                end else rs_b_cnt++;
            end
            if (rs_r_pend) begin
                if (rs_r_cnt >= r_wait) begin
                    rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; rs_r_pend = 0;
                end else rs_r_cnt++;
            end
            if (awvalid && !rs_aw_hs) begin
                if (rs_aw_cnt >= aw_lat) awready = 1;
                else begin awready = 0; rs_aw_cnt++; end
            end else begin awready = 0; rs_aw_cnt = 0; end
            if (wvalid && !rs_w_hs) begin
                if (rs_w_cnt >= w_lat) wready = 1;
                else begin wready = 0; rs_w_cnt++; end
            end else begin wready = 0; rs_w_cnt = 0; end
            arready = arvalid && !rs_ar_hs;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge aclk);
            if (aresetn && rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                    chk("rsp_resp", 32'(rsp_resp), 32'(exp_q[0].resp));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_q[0].to));
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "simulation did not finish");
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Returns 1ns after the accepting edge.
    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [31:0] e_rdata,
                        input logic [1:0] e_resp, input logic e_to);
        exp_t e;
        bit   ok;
        e.rdata = e_rdata; e.resp = e_resp; e.to = e_to;
        exp_q.push_back(e);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (cmd_ready) begin
                @(posedge aclk);
                ok = 1;
                break;
            end
        end
        #1;
        cmd_valid = 0;
        if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && cmd_ready) begin
                ok = 1;
                break;
            end
        end
        chk("done_timeout", 32'(ok), 32'd1);
        step();
    endtask

    task automatic zero_wait_write(input logic [31:0] addr, input logic [31:0] data);
        send(1'b1, addr, data, 4'hF, 32'h0, 2'b00, 1'b0);
        chk("zw_awvalid_n1", 32'(awvalid), 32'd1);
        chk("zw_wvalid_n1", 32'(wvalid), 32'd1);
        chk("zw_awaddr", awaddr, addr);
        chk("zw_wdata", wdata, data);
        chk("zw_wstrb", 32'(wstrb), 32'hF);
        chk("zw_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        step();
        chk("zw_awvalid_n2", 32'(awvalid), 32'd0);
        chk("zw_wvalid_n2", 32'(wvalid), 32'd0);
        chk("zw_bready_n2", 32'(bready), 32'd1);
        chk("zw_rsp_valid_n2", 32'(rsp_valid), 32'd0);
        step();
        chk("zw_rsp_valid_n3", 32'(rsp_valid), 32'd1);
        chk("zw_bready_n3", 32'(bready), 32'd0);
        chk("zw_cmd_ready_n3", 32'(cmd_ready), 32'd0);
        step();
        chk("zw_rsp_valid_n4", 32'(rsp_valid), 32'd0);
        chk("zw_cmd_ready_n4", 32'(cmd_ready), 32'd1);
    endtask

    initial begin : main
        int got;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1;
        aw_lat = 0; w_lat = 0; b_wait = 0; r_wait = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
        aresetn = 1;
        #1 aresetn = 0;
        #1;
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_awaddr", awaddr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_prot", 32'({awprot, arprot}), 32'd0);
        repeat (3) @(posedge aclk);
        #3 aresetn = 1;
        step();
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        zero_wait_write(32'h10, 32'hA5A5_0003);

        aw_lat = 3;
        send(1'b1, 32'h20, 32'h1234_5678, 4'h3, 32'h0, 2'b00, 1'b0);
        chk("sk_wstrb", 32'(wstrb), 32'h3);
        step();
        chk("sk_wvalid_n1", 32'(wvalid), 32'd0);
        chk("sk_awvalid_n1", 32'(awvalid), 32'd1);
        chk("sk_awaddr_n1", awaddr, 32'h20);
        step();
        chk("sk_awvalid_n2", 32'(awvalid), 32'd1);
        step();
        chk("sk_awvalid_n3", 32'(awvalid), 32'd1);
        chk("sk_awaddr_n3", awaddr, 32'h20);
        chk("sk_bready_n3", 32'(bready), 32'd0);
        step();
        chk("sk_awvalid_n4", 32'(awvalid), 32'd0);
        chk("sk_bready_n4", 32'(bready), 32'd1);
        wait_done();
        aw_lat = 0;

        b_wait = 1; cfg_bresp = 2'b11;
        send(1'b1, 32'h40, 32'hCAFE_F00D, 4'h5, 32'h0, 2'b11, 1'b0);
        wait_done();
        b_wait = 0; cfg_bresp = 2'b00;

        r_wait = 2; cfg_rdata = 32'h0000_000F; cfg_rresp = 2'b00;
        send(1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_000F, 2'b00, 1'b0);
        chk("rd_arvalid_n1", 32'(arvalid), 32'd1);
        chk("rd_araddr", araddr, 32'h0);
        chk("rd_awvalid_n1", 32'(awvalid), 32'd0);
        step();
        chk("rd_arvalid_n2", 32'(arvalid), 32'd0);
        chk("rd_rready_n2", 32'(rready), 32'd1);
        wait_done();
        r_wait = 0;

        rsp_ready = 0; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
        send(1'b0, 32'h44, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10, 1'b0);
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (rsp_valid) begin got = 1; break; end
        end
        chk("bp_rsp_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
            if (k < 4) @(negedge aclk);
        end
        @(posedge aclk);
        #1 rsp_ready = 1;
        step();
        chk("bp_rsp_valid_done", 32'(rsp_valid), 32'd0);
        chk("bp_cmd_ready_back", 32'(cmd_ready), 32'd1);
        cfg_rresp = 2'b00;

        aw_lat = 10;
        send(1'b1, 32'h30, 32'h55AA_55AA, 4'hF, 32'h0, 2'b00, 1'b0);
        step();
        step();
        chk("mr_awvalid_pre", 32'(awvalid), 32'd1);
        #2 aresetn = 0;
        #1;
        chk("mr_awvalid", 32'(awvalid), 32'd0);
        chk("mr_wvalid", 32'(wvalid), 32'd0);
        chk("mr_arvalid", 32'(arvalid), 32'd0);
        chk("mr_bready", 32'(bready), 32'd0);
        chk("mr_rready", 32'(rready), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete();
        step();
        step();
        aw_lat = 0;
        #3 aresetn = 1;
        step();
        chk("mr_cmd_ready_after", 32'(cmd_ready), 32'd1);
        zero_wait_write(32'h34, 32'h0BAD_CAFE);

`ifdef AXILITE_CMD_TIMEOUT_EN
        r_wait = 12; cfg_rdata = 32'hBAD0_BAD0; cfg_rresp = 2'b00;
        send(1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (rsp_valid) begin got = 1; break; end
        end
        chk("to_rsp_seen", 32'(got), 32'd1);
        chk("to_rsp_timeout_flag", 32'(rsp_timeout), 32'd1);
        @(posedge aclk);
        #1;
        chk("to_rsp_valid_gone", 32'(rsp_valid), 32'd0);
        chk("to_orphan_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("to_orphan_rready", 32'(rready), 32'd1);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (rvalid && rready) begin got = 1; break; end
            chk("to_cmd_ready_blocked", 32'(cmd_ready), 32'd0);
        end
        chk("to_late_r_seen", 32'(got), 32'd1);
        @(posedge aclk);
        #1;
        chk("to_cmd_ready_released", 32'(cmd_ready), 32'd1);
        chk("to_rready_dropped", 32'(rready), 32'd0);
        step();
        chk("to_late_not_forwarded", 32'(rsp_valid), 32'd0);
        r_wait = 0; cfg_rdata = 32'h0F0F_0F0F;
        send(1'b0, 32'hC, 32'h0, 4'h0, 32'h0F0F_0F0F, 2'b00, 1'b0);
        wait_done();
`endif

        repeat (3) step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
